// File: rtl/sdfa_pkg.sv
// Shared definitions for the sdfa neuron controller.
// State codes, width defaults and the drain timeout default.
package sdfa_pkg;

    localparam int DEF_W_WGT   = 9;
    localparam int DEF_W_SUM   = 10;
    localparam int DEF_W_LEN   = 8;
    localparam int DEF_TIMEOUT = 16;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_STREAM   = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_OUTPUT   = 3'd4;
    localparam logic [2:0] S_RELEASE  = 3'd5;

endpackage

// File: rtl/sdfa_addr_gen.sv
// Block address generator: one read per active cycle until len reads issued.
// idx counts reads issued; during streaming idx-1 is the element on the bus.
module sdfa_addr_gen
    import sdfa_pkg::*;
#(
    parameter int W_LEN = DEF_W_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             active,
    input  logic [W_LEN-1:0] base,
    input  logic [W_LEN-1:0] len,
    output logic             mem_re,
    output logic [W_LEN-1:0] mem_addr,
    output logic             first,
    output logic             last
);

    logic [W_LEN-1:0] base_q;
    logic [W_LEN-1:0] len_q;
    logic [W_LEN-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
        end else if (load) begin
            base_q <= base;
            len_q  <= len;
            idx_q  <= '0;
        end else if (active) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    // Address wraps naturally in W_LEN bits.
    assign mem_re   = active && (idx_q != len_q);
    assign mem_addr = mem_re ? base_q + idx_q : '0;
    assign first    = (idx_q == W_LEN'(1));
    assign last     = (idx_q == len_q);

endmodule

// File: rtl/sdfa_neuron_ctrl.sv
// Sequencer for one sdfa_neuron: fetch block, stream it, await the sum,
// and hand the sum downstream over valid/ready.
module sdfa_neuron_ctrl
    import sdfa_pkg::*;
#(
    parameter int W_WGT   = DEF_W_WGT,
    parameter int W_SUM   = DEF_W_SUM,
    parameter int W_LEN   = DEF_W_LEN,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_LEN-1:0] base_addr,
    input  logic [W_LEN-1:0] blk_len,
    output logic             busy,
    output logic             mem_re,
    output logic [W_LEN-1:0] mem_addr,
    input  logic             mem_spike,
    input  logic [W_WGT-1:0] mem_weight,
    output logic             n_cal_en,
    output logic             n_new_block,
    output logic             n_input_spike,
    output logic [W_WGT-1:0] n_weight,
    output logic             n_read_done,
    input  logic [W_SUM-1:0] n_sum,
    input  logic             n_cal_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_SUM-1:0] sum_out,
    output logic             err
);

    localparam int W_TO = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [W_TO-1:0] wait_q;
    logic            accept;
    logic            streaming;
    logic            rd_active;
    logic            first;
    logic            last;

    assign accept    = (state == S_IDLE) && start && (blk_len != '0);
    assign streaming = (state == S_STREAM);
    assign rd_active = (state == S_PREFETCH) || streaming;

    sdfa_addr_gen #(
        .W_LEN(W_LEN)
    ) u_addr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .active  (rd_active),
        .base    (base_addr),
        .len     (blk_len),
        .mem_re  (mem_re),
        .mem_addr(mem_addr),
        .first   (first),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wait_q  <= '0;
            sum_out <= '0;
            err     <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (accept) begin
                        state <= S_PREFETCH;
                        err   <= 1'b0;
                    end
                end
                (state == S_PREFETCH): state <= S_STREAM;
                (state == S_STREAM): begin
                    if (last) begin
                        state  <= S_DRAIN;
                        wait_q <= '0;
                    end
                end
                (state == S_DRAIN): begin
                    // A done arriving on the final wait cycle still wins.
                    if (n_cal_done) begin
                        sum_out <= n_sum;
                        state   <= S_OUTPUT;
                    end else if (wait_q == W_TO'(TIMEOUT - 1)) begin
                        sum_out <= '0;
                        err     <= 1'b1;
                        state   <= S_OUTPUT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                (state == S_OUTPUT): begin
                    if (out_ready) state <= S_RELEASE;
                end
                (state == S_RELEASE): state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign n_cal_en      = streaming;
    assign n_new_block   = streaming && first;
    assign n_input_spike = streaming && mem_spike;
    assign n_weight      = streaming ? mem_weight : '0;
    assign n_read_done   = (state == S_RELEASE);
    assign out_valid     = (state == S_OUTPUT);

endmodule

// File: tb/tb_sdfa_neuron_ctrl.sv
// Scoreboard bench for sdfa_neuron_ctrl with buffer and neuron models.
// Expected stream/result entries are queued at issue and checked by a monitor.
module tb_sdfa_neuron_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base_addr = '0;
    logic [7:0] blk_len = '0;
    logic       busy;
    logic       mem_re;
    logic [7:0] mem_addr;
    logic       mem_spike = 1'b0;
    logic [8:0] mem_weight = '0;
    logic       n_cal_en;
    logic       n_new_block;
    logic       n_input_spike;
    logic [8:0] n_weight;
    logic       n_read_done;
    logic [9:0] n_sum = '0;
    logic       n_cal_done = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] sum_out;
    logic       err;

    sdfa_neuron_ctrl #(
        .W_WGT(9), .W_SUM(10), .W_LEN(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_addr(base_addr), .blk_len(blk_len), .busy(busy),
        .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_spike(mem_spike), .mem_weight(mem_weight),
        .n_cal_en(n_cal_en), .n_new_block(n_new_block),
        .n_input_spike(n_input_spike), .n_weight(n_weight),
        .n_read_done(n_read_done), .n_sum(n_sum),
        .n_cal_done(n_cal_done), .out_valid(out_valid),
        .out_ready(out_ready), .sum_out(sum_out), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         c;
        logic       spk;
        logic [8:0] w;
        logic       first;
    } stream_t;

    typedef struct {
        int         c;
        logic [9:0] sum;
        logic       err;
    } res_t;

    stream_t sq[$];
    res_t    rq[$];
    stream_t se;

    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int blocks_done = 0;
    int acc_cyc = -10;
    bit prev_valid = 1'b0;

    bit         mspk[256];
    logic [8:0] mwgt[256];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Synchronous weight/spike buffer.
    always @(posedge clk) begin
        if (mem_re) begin
            mem_spike  <= mspk[mem_addr];
            mem_weight <= mwgt[mem_addr];
        end
    end

    // Neuron model: cal_done pulse done_delay cycles after cal_en drops.
    int done_delay = 0;
    int dc = 0;
    bit in_drain = 1'b0;
    always @(negedge clk) begin
        n_cal_done = 1'b0;
        if (rst) begin
            in_drain = 1'b0;
        end else if (n_cal_en) begin
            in_drain = 1'b1;
            dc = 0;
        end else if (in_drain) begin
            if (dc == done_delay) begin
                n_cal_done = 1'b1;
                in_drain = 1'b0;
            end else if (dc > TIMEOUT + 4) begin
                in_drain = 1'b0;
            end
            dc++;
        end
    end

    // Monitor.
    always @(negedge clk) begin
        if (n_cal_en) begin
            if (sq.size() == 0) begin
                fail("stream_extra");
            end else begin
                se = sq.pop_front();
                chk("stream_cycle", cyc, se.c);
                chk("spike", n_input_spike, se.spk);
                chk("weight", n_weight, se.w);
                chk("new_block", n_new_block, se.first);
                chk("err_in_stream", err, 0);
            end
        end
        if (out_valid) begin
            if (rq.size() == 0) begin
                fail("valid_extra");
            end else begin
                if (!prev_valid) chk("valid_cycle", cyc, rq[0].c);
                chk("sum_out", sum_out, rq[0].sum);
                chk("err_flag", err, rq[0].err);
                if (out_ready) begin
                    void'(rq.pop_front());
                    acc_cyc = cyc;
                end
            end
        end
        if (n_read_done) begin
            rd_pulses++;
            chk("read_done_cycle", cyc, acc_cyc + 1);
        end
        prev_valid = out_valid;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] blk_sum(input logic [7:0] base,
                                           input logic [7:0] len);
        logic [9:0] s;
        logic [7:0] a;
        s = '0;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 8'(i);
            if (mspk[a]) s = s + {mwgt[a][8], mwgt[a]};
        end
        return s;
    endfunction

    task automatic check_idle(input string name);
        chk({name, "_ctl"}, {busy, mem_re, n_cal_en, n_new_block,
            n_input_spike, n_read_done, out_valid, err}, 0);
        chk({name, "_data"}, {mem_addr, n_weight, sum_out}, 0);
    endtask

    task automatic issue(input logic [7:0] base, input logic [7:0] len,
                         input int delay, output int sc);
        logic [7:0] a;
        int d;
        start = 1'b1;
        base_addr = base;
        blk_len = len;
        sc = cyc;
        n_sum = blk_sum(base, len);
        done_delay = delay;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 8'(i);
            sq.push_back('{c: sc + 2 + i, spk: mspk[a], w: mwgt[a],
                           first: (i == 0)});
        end
        d = (delay < TIMEOUT) ? delay : TIMEOUT - 1;
        rq.push_back('{c: sc + int'(len) + 3 + d,
                       sum: (delay < TIMEOUT) ? n_sum : 10'd0,
                       err: (delay >= TIMEOUT)});
        tick;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_after_start", err, 0);
    endtask

    task automatic finish_block(input int bp);
        out_ready = 1'b0;
        for (int k = 0; k < 200 && !out_valid; k++) tick;
        if (!out_valid) begin
            fail("out_valid_timeout");
            rst = 1'b1;
            tick;
            rst = 1'b0;
            sq.delete();
            rq.delete();
            return;
        end
        repeat (bp) tick;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        tick;
        chk("busy_idle", busy, 0);
        chk("stream_q_empty", sq.size(), 0);
        chk("res_q_empty", rq.size(), 0);
        blocks_done++;
    endtask

    task automatic run_block(input logic [7:0] base, input logic [7:0] len,
                             input int delay, input int bp);
        int sc;
        issue(base, len, delay, sc);
        finish_block(bp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;
        for (int i = 0; i < 256; i++) begin
            mspk[i] = 1'($urandom);
            mwgt[i] = 9'($urandom);
        end
        repeat (3) tick;
        rst = 1'b0;
        check_idle("reset");

        // Basic block.
        for (int i = 0; i < 3; i++) begin
            mspk[8'h10 + i] = 1'b1;
            mwgt[8'h10 + i] = 9'(i + 1);
        end
        run_block(8'h10, 8'd3, 0, 0);
        chk("basic_sum_model", blk_sum(8'h10, 8'd3), 10'd6);

        // Backpressure.
        run_block(8'h10, 8'd3, 0, 5);

        // Negative weights and zero spike.
        mspk[8'h30] = 1'b1; mwgt[8'h30] = 9'h1FF;
        mspk[8'h31] = 1'b0; mwgt[8'h31] = 9'h100;
        mspk[8'h32] = 1'b1; mwgt[8'h32] = 9'h100;
        run_block(8'h30, 8'd3, 0, 1);

        // Zero-length start is ignored.
        start = 1'b1;
        blk_len = 8'd0;
        tick;
        start = 1'b0;
        chk("len0_busy_a", busy, 0);
        tick;
        chk("len0_busy_b", busy, 0);

        // Second start during STREAM is ignored.
        issue(8'h20, 8'd8, 2, sc);
        tick;
        start = 1'b1;
        base_addr = 8'h77;
        blk_len = 8'd3;
        tick;
        start = 1'b0;
        finish_block(0);
        tick;
        chk("no_queued_start", busy, 0);

        // Address wrap.
        run_block(8'hFE, 8'd4, 0, 0);

        // Done on the last allowed drain cycle, then full timeout.
        run_block(8'h44, 8'd2, TIMEOUT - 1, 0);
        run_block(8'h50, 8'd4, 1000, 2);
        run_block(8'h60, 8'd3, 0, 0);

        // Reset on the second stream cycle.
        issue(8'h40, 8'd5, 0, sc);
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        sq.delete();
        rq.delete();
        check_idle("mid_reset");
        repeat (3) tick;
        chk("mid_reset_busy", busy, 0);
        run_block(8'h40, 8'd5, 1, 0);

        // Randomized blocks.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] b;
            logic [7:0] l;
            b = 8'($urandom);
            l = (n % 10 == 9) ? 8'd40 : 8'($urandom_range(1, 12));
            run_block(b, l, $urandom_range(0, 17), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) tick;
        end

        chk("read_done_count", rd_pulses, blocks_done);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
